shift_sequencer: RTL and testbench

Command-driven controller for the team's single-bit sequential shift register. It accepts a multi-bit shift command over a valid/ready handshake and parallel-loads the shifter. It then pulses the shifter's shift enable once per cycle for the requested amount and returns the result, plus the last bit shifted out, on a valid/ready response channel. It sits between a requesting datapath and one shift-register instance and owns all of that instance's control inputs.

---
 rtl/shift_sequencer_pkg.sv | 11 +
 rtl/shift_sequencer_count.sv | 18 +
 rtl/shift_sequencer.sv | 74 +++++++
 tb/tb_shift_sequencer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// shift_sequencer_pkg: state encoding and count-width helper shared by the shift sequencer
package shift_sequencer_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t LOAD  = 2'd1;
  localparam state_t SHIFT = 2'd2;
  localparam state_t DONE  = 2'd3;
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/shift_sequencer_count.sv
// shift_count: loadable down-counter with a terminal-count flag (count == 1)
module shift_count #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             tc
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (load) count <= load_val;
    else if (dec) count <= count - 1'b1;
  assign tc = count == CNT_W'(1);
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: command-driven controller that loads, steps and reads back one shift register
module shift_sequencer import shift_sequencer_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_amount,
  input  logic             cmd_dir,
  input  logic             cmd_mode,
  input  logic             cmd_fill,
  output logic             sh_load,
  output logic [WIDTH-1:0] sh_data,
  output logic             sh_shift_en,
  output logic             sh_dir,
  output logic             sh_mode,
  output logic             sh_serial_in,
  input  logic [WIDTH-1:0] sh_data_out,
  input  logic             sh_serial_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_last_out,
  output logic             busy
);
  state_t state, state_nxt;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] count, eff_amount;
  logic dir_q, mode_q, fill_q, last_q, tc, accept;
  assign cmd_ready = rst_n && state == IDLE;
  assign accept = cmd_valid && cmd_ready;
  assign eff_amount = cmd_amount > CNT_W'(WIDTH) ? CNT_W'(WIDTH) : cmd_amount;
  shift_count #(.CNT_W(CNT_W)) u_count (
    .clk(clk), .rst_n(rst_n), .load(accept), .dec(state == SHIFT),
    .load_val(eff_amount), .count(count), .tc(tc)
  );
  always_comb
    state_nxt = state == IDLE  ? (accept ? LOAD : IDLE) :
                state == LOAD  ? (count != '0 ? SHIFT : DONE) :
                state == SHIFT ? (tc ? DONE : SHIFT) :
                                 (rsp_ready ? IDLE : DONE);
  // last_q clears on accept so a zero-amount command reports 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      data_q <= '0;
      dir_q  <= 1'b0;
      mode_q <= 1'b0;
      fill_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        data_q <= cmd_data;
        dir_q  <= cmd_dir;
        mode_q <= cmd_mode;
        fill_q <= cmd_fill;
        last_q <= 1'b0;
      end else if (state == SHIFT) last_q <= sh_serial_out;
    end
  assign busy         = state != IDLE;
  assign sh_load      = state == LOAD;
  assign sh_data      = sh_load ? data_q : '0;
  assign sh_shift_en  = state == SHIFT;
  assign sh_dir       = dir_q;
  assign sh_mode      = mode_q;
  assign sh_serial_in = fill_q;
  assign rsp_valid    = state == DONE;
  assign rsp_data     = rsp_valid ? sh_data_out : '0;
  assign rsp_last_out = rsp_valid && last_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed vectors against a behavioural shift register attached to the sequencer
module tb_shift_sequencer;
  localparam int W = 8;
  localparam int CW = 4;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_dir = 0, cmd_mode = 0, cmd_fill = 0, rsp_ready = 1;
  logic [W-1:0] cmd_data = '0;
  logic [CW-1:0] cmd_amount = '0;
  logic cmd_ready, sh_load, sh_shift_en, sh_dir, sh_mode, sh_serial_in, sh_serial_out;
  logic rsp_valid, rsp_last_out, busy;
  logic [W-1:0] sh_data, sh_data_out, rsp_data, sr;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  shift_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_amount(cmd_amount), .cmd_dir(cmd_dir),
    .cmd_mode(cmd_mode), .cmd_fill(cmd_fill), .sh_load(sh_load), .sh_data(sh_data),
    .sh_shift_en(sh_shift_en), .sh_dir(sh_dir), .sh_mode(sh_mode),
    .sh_serial_in(sh_serial_in), .sh_data_out(sh_data_out),
    .sh_serial_out(sh_serial_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_last_out(rsp_last_out), .busy(busy)
  );

  // reference shift register owned by the enclosing level
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= '0;
    else if (sh_load) sr <= sh_data;
    else if (sh_shift_en)
      sr <= !sh_dir ? {sr[W-2:0], sh_serial_in} :
            sh_mode ? {sr[W-1], sr[W-1:1]} : {sh_serial_in, sr[W-1:1]};
  assign sh_data_out = sr;
  assign sh_serial_out = sh_dir ? sr[0] : sr[W-1];

  typedef struct {
    logic [W-1:0] data;
    logic [CW-1:0] amount;
    logic dir, mode, fill;
    logic [W-1:0] exp_data;
    logic exp_last;
    int exp_pulses;
    bit hold;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int cyc, pulses, loads, ovl;
    logic [W-1:0] held;
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_data = v.data; cmd_amount = v.amount; cmd_dir = v.dir;
    cmd_mode = v.mode; cmd_fill = v.fill; cmd_valid = 1;
    rsp_ready = !v.hold;
    @(posedge clk); #1 cmd_valid = 0;
    cyc = 0; pulses = 0; loads = 0; ovl = 0;
    do begin
      @(negedge clk);
      cyc++;
      pulses += int'(sh_shift_en);
      loads += int'(sh_load);
      ovl += int'(sh_load && sh_shift_en);
    end while (!rsp_valid && cyc < 40);
    chk("rsp_latency", cyc, v.exp_pulses + 2);
    chk("rsp_data", rsp_data, v.exp_data);
    chk("rsp_last_out", rsp_last_out, v.exp_last);
    chk("shift_pulses", pulses, v.exp_pulses);
    chk("load_pulses", loads, 1);
    chk("load_shift_overlap", ovl, 0);
    if (v.hold) begin
      held = rsp_data;
      cmd_valid = 1; cmd_data = 8'h33; cmd_amount = 4'd1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("hold_valid", rsp_valid, 1);
        chk("hold_data", rsp_data, held);
        chk("hold_last", rsp_last_out, v.exp_last);
        chk("hold_cmd_ready", cmd_ready, 0);
        chk("hold_no_load", sh_load, 0);
      end
      cmd_valid = 0;
      rsp_ready = 1;
    end
    @(negedge clk);
    chk("idle_after_rsp_ready", cmd_ready, 1);
    chk("idle_after_rsp_valid", rsp_valid, 0);
    chk("idle_after_rsp_busy", busy, 0);
  endtask

  initial begin
    vecs[0] = '{8'hB4, 4'd3,  1'b0, 1'b0, 1'b0, 8'hA0, 1'b1, 3, 1'b0};
    vecs[1] = '{8'h96, 4'd2,  1'b1, 1'b1, 1'b0, 8'hE5, 1'b1, 2, 1'b0};
    vecs[2] = '{8'h0F, 4'd4,  1'b1, 1'b0, 1'b1, 8'hF0, 1'b1, 4, 1'b0};
    vecs[3] = '{8'h5A, 4'd0,  1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 0, 1'b0};
    vecs[4] = '{8'h00, 4'd8,  1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 8, 1'b0};
    vecs[5] = '{8'hFF, 4'd12, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8, 1'b1};
    #2;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_outputs", {busy, rsp_valid, rsp_last_out, rsp_data, sh_load, sh_data,
        sh_shift_en, sh_dir, sh_mode, sh_serial_in}, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);
    for (int i = 0; i < 6; i++) run(vecs[i]);
    cmd_data = 8'hC3; cmd_amount = 4'd5; cmd_dir = 1; cmd_mode = 0; cmd_fill = 1; cmd_valid = 1;
    @(posedge clk); #1 cmd_valid = 0;
    repeat (3) @(negedge clk);
    chk("second_shift_cycle", sh_shift_en, 1);
    #1 rst_n = 0;
    #1;
    chk("abort_cmd_ready", cmd_ready, 0);
    chk("abort_outputs", {busy, rsp_valid, rsp_last_out, rsp_data, sh_load, sh_data,
        sh_shift_en, sh_dir, sh_mode, sh_serial_in}, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    chk("abort_recover_rsp", rsp_valid, 0);
    run(vecs[0]);
    run(vecs[3]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
